// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: mode encodings and single-step helpers.
// Helpers operate on a 64-bit container; callers pass the real width.
package lfsr_pkg;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;
  localparam int MAX_W          = 64;

  // Output bit of a state: the MSB in both modes.
  function automatic logic lfsr_obit(input logic [MAX_W-1:0] s, input int unsigned w);
    logic [5:0] msb;
    msb = 6'(w - 1);
    return s[msb];
  endfunction

  // One left-shifting LFSR step; result masked back to w bits.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] taps,
                                                 input int              mode,
                                                 input int unsigned     w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] nxt;
    logic             o;
    mask = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    o    = lfsr_obit(s, w);
    if (mode == MODE_GALOIS) nxt = (s << 1) ^ ({MAX_W{o}} & taps);
    else                     nxt = (s << 1) | {{(MAX_W-1){1'b0}}, ^(s & taps)};
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational STEP-deep unroll of the LFSR: word bit k is the output
// bit of sub-state k, next_state is the state after STEP steps.
module lfsr_step_unroll
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter int               MODE  = MODE_FIBONACCI,
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [STEP-1:0]  word,
  output logic [WIDTH-1:0] next_state
);

  logic [STEP:0][WIDTH-1:0] chain;

  assign chain[0] = state;

  // Each sub-stage emits one output bit and feeds the next sub-stage.
  for (genvar k = 0; k < STEP; k++) begin : g_sub
    assign word[k]       = lfsr_obit(64'(chain[k]), WIDTH);
    assign chain[k+1]    = WIDTH'(lfsr_step(64'(chain[k]), 64'(TAPS), MODE, WIDTH));
  end

  assign next_state = chain[STEP];

endmodule

// File: rtl/lfsr_stream_gen.sv
// PRBS word source on a valid/ready stream with lockup recovery and
// period detection. Optional word counter enabled by LFSR_WORD_CNT_EN.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter int               MODE         = MODE_FIBONACCI,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [STEP-1:0]  out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] state,
  output logic             period_done,
  output logic             lockup
`ifdef LFSR_WORD_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] nxt_state;
  logic [STEP-1:0]  word;
  logic             adv;

  lfsr_step_unroll #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MODE),
    .STEP  (STEP)
  ) u_unroll (
    .state      (state_r),
    .word       (word),
    .next_state (nxt_state)
  );

  // A zero seed would lock the register, so substitute the default.
  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign adv      = enable && !load && (!out_valid || out_ready);
  assign state    = state_r;

  // State, output word, handshake, lockup and period tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DEFAULT_SEED;
      seed_reg    <= DEFAULT_SEED;
      out_data    <= '0;
      out_valid   <= 1'b0;
      period_done <= 1'b0;
      lockup      <= 1'b0;
    end else if (load) begin
      state_r     <= seed_eff;
      seed_reg    <= seed_eff;
      out_valid   <= 1'b0;
      period_done <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (adv) begin
        out_valid <= 1'b1;
        if (state_r == '0) begin
          state_r  <= DEFAULT_SEED;
          lockup   <= 1'b1;
          out_data <= '0;
        end else begin
          state_r     <= nxt_state;
          out_data    <= word;
          period_done <= (nxt_state == seed_reg);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LFSR_WORD_CNT_EN
  // Accepted-transfer counter; load clears it even on a coincident accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      word_cnt <= '0;
    else if (load)                   word_cnt <= '0;
    else if (out_valid && out_ready) word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule
